// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive path: synced line-state codes and the
// receive FSM encoding.
package usb_rx_pkg;

  // {dp, dn} after synchronisation
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_SE1 = 2'b11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SYNC = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_EOP  = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

endpackage

// File: rtl/usb_rx_dpll.sv
// Line synchroniser and digital phase recovery: re-centres the bit sampling
// point on every synced line-state change.
module usb_rx_dpll
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 10
) (
  input  logic       useClk,
  input  logic       reset,
  input  logic       dp,
  input  logic       dn,
  output logic       sampleStb,
  output logic [1:0] lineState
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] SAMPLE_PHASE = PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] LAST_PHASE   = PW'(OVERSAMPLE - 1);

  logic [1:0]    r_meta;
  logic [1:0]    r_sync;
  logic [1:0]    r_last;
  logic [PW-1:0] r_phase;
  logic [PW-1:0] w_phase;

  // A line change makes the current cycle phase 0, so the sample lands
  // OVERSAMPLE/2 cycles after the synced edge.
  assign w_phase   = (r_sync != r_last) ? '0 : r_phase;
  assign sampleStb = (w_phase == SAMPLE_PHASE);
  assign lineState = r_sync;

  always_ff @(posedge useClk) begin
    if (reset) begin
      r_meta  <= LINE_J;
      r_sync  <= LINE_J;
      r_last  <= LINE_J;
      r_phase <= '0;
    end else begin
      r_meta  <= {dp, dn};
      r_sync  <= r_meta;
      r_last  <= r_sync;
      r_phase <= (w_phase == LAST_PHASE) ? '0 : w_phase + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// USB receive front end: NRZI decode, bit unstuffing, SYNC/EOP framing and
// LSB-first word assembly on top of the phase-recovery block.
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE     = 10,
  parameter int DATA_W         = 8,
  parameter int STUFF_LEN      = 6,
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic              useClk,
  input  logic              reset,
  input  logic              dp,
  input  logic              dn,
  output logic [DATA_W-1:0] rxData,
  output logic              rxValid,
  output logic              rxActive,
  output logic              eop,
  output logic              stuffErr,
  output logic              byteErr
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam int OW = $clog2(STUFF_LEN + 1);
  localparam int ZW = $clog2(SYNC_MIN_ZEROS + 1);
  localparam logic [BW-1:0] BIT_FULL = BW'(DATA_W);
  localparam logic [OW-1:0] ONES_MAX = OW'(STUFF_LEN);
  localparam logic [ZW-1:0] ZERO_SAT = ZW'(SYNC_MIN_ZEROS);

  logic              w_stb;
  logic [1:0]        w_line;
  logic              w_is_data_sym;
  logic              w_bit;
  logic              w_stuff_viol;
  logic [BW-1:0]     w_bit_base;

  logic [2:0]        r_state;
  logic [1:0]        r_prev_line;
  logic [OW-1:0]     r_ones;
  logic [BW-1:0]     r_bit_cnt;
  logic [ZW-1:0]     r_zeros;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_active;
  logic              r_eop;
  logic              r_stuff_err;
  logic              r_byte_err;

  usb_rx_dpll #(.OVERSAMPLE(OVERSAMPLE)) u_dpll (
    .useClk    (useClk),
    .reset     (reset),
    .dp        (dp),
    .dn        (dn),
    .sampleStb (w_stb),
    .lineState (w_line)
  );

  assign w_is_data_sym = (w_line == LINE_J) || (w_line == LINE_K);
  assign w_bit         = (w_line == r_prev_line);
  assign w_stuff_viol  = w_stb && (r_state == ST_DATA) && w_is_data_sym &&
                         (r_ones == ONES_MAX) && w_bit;
  assign w_bit_base    = (r_bit_cnt == BIT_FULL) ? '0 : r_bit_cnt;

  always_ff @(posedge useClk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prev_line <= LINE_J;
      r_ones      <= '0;
      r_bit_cnt   <= '0;
      r_zeros     <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_active    <= 1'b0;
      r_eop       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_byte_err  <= 1'b0;
    end else begin
      // NOTE: strobes default low here and are raised below, so each is a
      // single-cycle pulse; every register in this block uses <= only.
      r_rx_valid  <= 1'b0;
      r_eop       <= 1'b0;
      r_stuff_err <= 1'b0;
      r_byte_err  <= 1'b0;

      if (r_bit_cnt == BIT_FULL) begin
        r_bit_cnt <= '0;
        if (!w_stuff_viol) begin
          r_rx_valid <= 1'b1;
          r_rx_data  <= r_shift;
        end
      end

      if (w_stb) begin
        if (w_is_data_sym) r_prev_line <= w_line;
        case (r_state)
          ST_IDLE: if (w_line == LINE_K) begin
            r_state <= ST_SYNC;
            r_zeros <= ZW'(1);
          end
          ST_SYNC: begin
            if (w_line == LINE_SE0) r_state <= ST_IDLE;
            else if (w_line == LINE_SE1) r_state <= ST_ERR;
            else if (!w_bit) begin
              if (r_zeros != ZERO_SAT) r_zeros <= r_zeros + 1'b1;
            end else if (r_zeros >= ZERO_SAT) begin
              r_state   <= ST_DATA;
              r_active  <= 1'b1;
              r_ones    <= '0;
              r_bit_cnt <= '0;
            end else r_state <= ST_IDLE;
          end
          ST_DATA: begin
            if (w_line == LINE_SE0) r_state <= ST_EOP;
            else if (w_line == LINE_SE1) begin
              r_state  <= ST_ERR;
              r_active <= 1'b0;
            end else if (r_ones == ONES_MAX) begin
              // the bit after a full run of ones must be the stuffed 0
              if (w_bit) begin
                r_stuff_err <= 1'b1;
                r_state     <= ST_ERR;
                r_active    <= 1'b0;
              end else r_ones <= '0;
            end else begin
              r_shift   <= {w_bit, r_shift[DATA_W-1:1]};
              r_ones    <= w_bit ? r_ones + 1'b1 : '0;
              r_bit_cnt <= w_bit_base + 1'b1;
            end
          end
          ST_EOP: begin
            if (w_line == LINE_J) begin
              r_eop      <= 1'b1;
              r_byte_err <= (r_bit_cnt != '0);
              r_active   <= 1'b0;
              r_bit_cnt  <= '0;
              r_state    <= ST_IDLE;
            end else if (w_line != LINE_SE0) begin
              r_state  <= ST_ERR;
              r_active <= 1'b0;
            end
          end
          ST_ERR: if (w_line == LINE_J) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign rxData   = r_rx_data;
  assign rxValid  = r_rx_valid;
  assign rxActive = r_active;
  assign eop      = r_eop;
  assign stuffErr = r_stuff_err;
  assign byteErr  = r_byte_err;

endmodule
